// File: rtl/hazard_forward_unit_pkg.sv
// hazard_forward_unit_pkg
//   Shared types and constants for the hazard / forwarding unit.
//   slot_t      : one tracked pipeline slot (valid, rd, regwrite, is_load)
//   SEL_RF      : fwd_sel encoding for "take the operand from the register file"
//   slot_writes : true when a slot is a live producer of a nonzero register
package hazard_forward_unit_pkg;

  // Widest register address a slot can carry; narrower addresses are
  // zero-extended so the slot type does not depend on module parameters.
  localparam int unsigned RD_MAX_W = 16;

  // fwd_sel value meaning "no forwarding, use the register file".
  localparam int unsigned SEL_RF = 0;

  typedef struct packed {
    logic                valid;
    logic [RD_MAX_W-1:0] rd;
    logic                regwrite;
    logic                is_load;
  } slot_t;

  localparam slot_t BUBBLE = '{
    valid:    1'b0,
    rd:       {RD_MAX_W{1'b0}},
    regwrite: 1'b0,
    is_load:  1'b0
  };

  // x0 is hard-wired to zero, so a slot writing x0 is never a producer.
  function automatic logic slot_writes(input slot_t s, input logic [RD_MAX_W-1:0] reg_addr);
    return s.valid && s.regwrite && (s.rd != {RD_MAX_W{1'b0}}) && (s.rd == reg_addr);
  endfunction

endpackage

// File: rtl/hazard_forward_unit_fwd_match_prio.sv
// fwd_match_prio
//   Compares one EX source register against the post-EX producer slots and
//   returns the index of the youngest (lowest-numbered) matching producer.
//   src_i   : EX source register address
//   slots_i : producer slots 1..FWD_DEPTH (slot 1 = MEM, youngest)
//   sel_o   : 0 (SEL_RF) when nothing matches, else the matching slot index
module fwd_match_prio
  import hazard_forward_unit_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned FWD_DEPTH  = 2,
  parameter int unsigned SEL_W      = $clog2(FWD_DEPTH + 1)
) (
  input  logic [REG_ADDR_W-1:0] src_i,
  input  slot_t [FWD_DEPTH:1]   slots_i,
  output logic [SEL_W-1:0]      sel_o
);

  logic [RD_MAX_W-1:0] src_ext_s;
  logic                unused_load_s;

  assign src_ext_s = RD_MAX_W'(src_i);

  // Priority select: scan oldest to youngest so the youngest match lands last.
  always_comb begin
    sel_o = SEL_W'(SEL_RF);
    for (int k = int'(FWD_DEPTH); k >= 1; k--) begin
      sel_o = slot_writes(slots_i[k], src_ext_s) ? SEL_W'(k) : sel_o;
    end
  end

  // Load flag is irrelevant here: a load that reached slot >=1 is forwardable.
  always_comb begin
    unused_load_s = 1'b0;
    for (int k = 1; k <= int'(FWD_DEPTH); k++) begin
      unused_load_s = unused_load_s ^ slots_i[k].is_load;
    end
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit
//   Tracks in-flight instructions from EX onward, selects operand forwarding
//   for the instruction in EX and detects load-use hazards for the one in ID.
//   clk, reset              : rising-edge clock, synchronous active-high reset
//   id_valid/id_rs/id_rd    : instruction in ID (sources packed REG_ADDR_W each)
//   id_regwrite/id_is_load  : ID instruction writes rd / is a load
//   freeze                  : external hold of the whole pipeline
//   flush                   : kill ID and EX
//   fwd_sel                 : per-source EX operand select (0 = register file)
//   hazard_stall            : hold PC/IF/ID and insert a bubble into EX
//   ex_valid                : EX holds a live instruction
//   stall_count             : saturating count of load-use stall cycles
module hazard_forward_unit
  import hazard_forward_unit_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned NUM_SRC    = 2,
  parameter int unsigned FWD_DEPTH  = 2,
  parameter int unsigned LOAD_SLOT  = 2,
  parameter int unsigned SEL_W      = $clog2(FWD_DEPTH + 1)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          id_valid,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0]         id_rd,
  input  logic                          id_regwrite,
  input  logic                          id_is_load,
  input  logic                          freeze,
  input  logic                          flush,
  output logic [NUM_SRC*SEL_W-1:0]      fwd_sel,
  output logic                          hazard_stall,
  output logic                          ex_valid,
  output logic [15:0]                   stall_count
);

  localparam int unsigned RS_W = NUM_SRC * REG_ADDR_W;

  slot_t [FWD_DEPTH:0] slot_q, slot_d;
  logic [RS_W-1:0]     ex_rs_q, ex_rs_d;
  logic [15:0]         stall_cnt_q, stall_cnt_d;
  slot_t               id_slot_s;
  logic                load_use_s;
  logic                issue_s;

  assign id_slot_s = '{
    valid:    1'b1,
    rd:       RD_MAX_W'(id_rd),
    regwrite: id_regwrite,
    is_load:  id_is_load
  };

  // Load-use detection: a load in slot j is usable by ID only once it reaches
  // slot LOAD_SLOT-1, so any younger load producing an ID source must stall.
  always_comb begin
    load_use_s = 1'b0;
    for (int j = 0; j < int'(LOAD_SLOT) - 1; j++) begin
      for (int i = 0; i < int'(NUM_SRC); i++) begin
        load_use_s = load_use_s
                   | (slot_q[j].is_load
                      & slot_writes(slot_q[j], RD_MAX_W'(id_rs[i*REG_ADDR_W +: REG_ADDR_W])));
      end
    end
  end

  assign hazard_stall = id_valid & ~flush & load_use_s;
  assign issue_s      = id_valid & ~hazard_stall & ~flush;

  // Next-state: shift on advance, hold on freeze; flush always empties EX.
  // Bubbles carry x0 sources so they can never request forwarding.
  always_comb begin
    slot_d      = slot_q;
    ex_rs_d     = ex_rs_q;
    stall_cnt_d = stall_cnt_q;
    if (!freeze) begin
      for (int k = 1; k <= int'(FWD_DEPTH); k++) begin
        slot_d[k] = slot_q[k-1];
      end
      if (issue_s) begin
        slot_d[0] = id_slot_s;
        ex_rs_d   = id_rs;
      end else begin
        slot_d[0] = BUBBLE;
        ex_rs_d   = {RS_W{1'b0}};
      end
      if (hazard_stall && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_d = stall_cnt_q + 16'd1;
      end else begin
        stall_cnt_d = stall_cnt_q;
      end
    end else if (flush) begin
      slot_d[0] = BUBBLE;
      ex_rs_d   = {RS_W{1'b0}};
    end else begin
      slot_d      = slot_q;
      ex_rs_d     = ex_rs_q;
      stall_cnt_d = stall_cnt_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_q      <= {(FWD_DEPTH + 1){BUBBLE}};
      ex_rs_q     <= {RS_W{1'b0}};
      stall_cnt_q <= 16'h0000;
    end else begin
      slot_q      <= slot_d;
      ex_rs_q     <= ex_rs_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign ex_valid    = slot_q[0].valid;
  assign stall_count = stall_cnt_q;

  for (genvar gi = 0; gi < int'(NUM_SRC); gi++) begin : g_src
    fwd_match_prio #(
      .REG_ADDR_W(REG_ADDR_W),
      .FWD_DEPTH (FWD_DEPTH),
      .SEL_W     (SEL_W)
    ) u_match (
      .src_i  (ex_rs_q[gi*REG_ADDR_W +: REG_ADDR_W]),
      .slots_i(slot_q[FWD_DEPTH:1]),
      .sel_o  (fwd_sel[gi*SEL_W +: SEL_W])
    );
  end

endmodule

// File: tb/tb_hazard_forward_unit.sv
module tb_hazard_forward_unit;

  localparam int FD = 2;
  localparam int LS = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // default-parameter instance
  logic        rst, idv, rw, ld, frz, fl;
  logic [9:0]  rs;
  logic [4:0]  rd;
  logic [3:0]  fsel;
  logic        hst, exv;
  logic [15:0] cnt;

  // deep instance used for the saturation run (31 stall cycles per load)
  logic        rst2, idv2, rw2, ld2, frz2, fl2;
  logic [9:0]  rs2;
  logic [4:0]  rd2;
  logic [11:0] fsel2;
  logic        hst2, exv2;
  logic [15:0] cnt2;

  hazard_forward_unit dut (
    .clk(clk), .reset(rst), .id_valid(idv), .id_rs(rs), .id_rd(rd),
    .id_regwrite(rw), .id_is_load(ld), .freeze(frz), .flush(fl),
    .fwd_sel(fsel), .hazard_stall(hst), .ex_valid(exv), .stall_count(cnt)
  );

  hazard_forward_unit #(.FWD_DEPTH(32), .LOAD_SLOT(32)) dut_deep (
    .clk(clk), .reset(rst2), .id_valid(idv2), .id_rs(rs2), .id_rd(rd2),
    .id_regwrite(rw2), .id_is_load(ld2), .freeze(frz2), .flush(fl2),
    .fwd_sel(fsel2), .hazard_stall(hst2), .ex_valid(exv2), .stall_count(cnt2)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input int v, input int r0, input int r1, input int d,
                       input int w, input int l, input int fz, input int f);
    idv = (v != 0);
    rs  = {5'(r1), 5'(r0)};
    rd  = 5'(d);
    rw  = (w != 0);
    ld  = (l != 0);
    frz = (fz != 0);
    fl  = (f != 0);
  endtask

  task automatic check_outs(input string tag, input int f0, input int f1,
                            input int st, input int ev, input int c);
    check({tag, ".fwd0"}, int'(fsel[1:0]), f0);
    check({tag, ".fwd1"}, int'(fsel[3:2]), f1);
    check({tag, ".stall"}, int'(hst), st);
    check({tag, ".ex_valid"}, int'(exv), ev);
    check({tag, ".count"}, int'(cnt), c);
  endtask

  // ---------------- reference model ----------------
  // The pipeline is a list of instruction records, newest first; entry k is
  // the instruction k stages past EX. Missing entries are empty stages.
  typedef struct {
    bit valid;
    int rd;
    bit rw;
    bit ld;
    int rs0;
    int rs1;
  } rec_t;

  rec_t mq[$];
  int   m_cnt = 0;

  function automatic rec_t m_empty();
    rec_t r;
    r.valid = 0; r.rd = 0; r.rw = 0; r.ld = 0; r.rs0 = 0; r.rs1 = 0;
    return r;
  endfunction

  function automatic rec_t m_get(input int k);
    if (k < mq.size()) return mq[k];
    return m_empty();
  endfunction

  function automatic int m_fwd(input int src);
    for (int k = 1; k <= FD; k++) begin
      rec_t p = m_get(k);
      if (p.valid && p.rw && p.rd != 0 && p.rd == src) return k;
    end
    return 0;
  endfunction

  function automatic bit m_stall(input int v, input int r0, input int r1, input int f);
    if (v == 0 || f != 0) return 0;
    for (int j = 0; j < LS - 1; j++) begin
      rec_t p = m_get(j);
      if (p.valid && p.rw && p.ld && p.rd != 0 && (p.rd == r0 || p.rd == r1)) return 1;
    end
    return 0;
  endfunction

  task automatic m_update(input int r, input int v, input int r0, input int r1,
                          input int d, input int w, input int l, input int fz,
                          input int f, input bit st);
    rec_t n;
    if (r != 0) begin
      mq.delete();
      m_cnt = 0;
    end else if (fz == 0) begin
      n = m_empty();
      if (v != 0 && !st && f == 0) begin
        n.valid = 1; n.rd = d; n.rw = (w != 0); n.ld = (l != 0); n.rs0 = r0; n.rs1 = r1;
      end
      mq.push_front(n);
      while (mq.size() > FD + 1) void'(mq.pop_back());
      if (st && m_cnt < 65535) m_cnt++;
    end else if (f != 0) begin
      if (mq.size() > 0) mq[0] = m_empty();
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    int v, r0, r1, d, w, l, fz, f;   // inputs
    int f0, f1, st, ev, c;           // expected outputs this cycle
  } vec_t;

  vec_t tbl[29];

  initial begin
    tbl[0]  = '{1, 1, 2, 5, 1,0,0,0,  0,0,0,0,0};  // add x5
    tbl[1]  = '{1, 5, 0, 6, 1,0,0,0,  0,0,0,1,0};  // reads x5 back-to-back
    tbl[2]  = '{1, 3, 5, 8, 1,0,0,0,  1,0,0,1,0};  // x5 from MEM
    tbl[3]  = '{0, 0, 0, 0, 0,0,0,0,  0,2,0,1,0};  // x5 from WB (one gap)
    tbl[4]  = '{1, 0, 0, 7, 1,0,0,0,  0,0,0,0,0};  // x7 producer a
    tbl[5]  = '{1, 0, 0, 7, 1,0,0,0,  0,0,0,1,0};  // x7 producer b
    tbl[6]  = '{1, 7, 7, 9, 1,0,0,0,  0,0,0,1,0};  // reads x7 twice
    tbl[7]  = '{0, 0, 0, 0, 0,0,0,0,  1,1,0,1,0};  // youngest wins
    tbl[8]  = '{1, 0, 0, 0, 1,0,0,0,  0,0,0,0,0};  // writes x0
    tbl[9]  = '{1, 0, 0,10, 1,0,0,0,  0,0,0,1,0};  // reads x0
    tbl[10] = '{1, 1, 0, 3, 1,1,0,0,  0,0,0,1,0};  // lw x3 ; x0 never forwards
    tbl[11] = '{1, 3, 2, 4, 1,0,0,0,  0,0,1,1,0};  // load-use stall
    tbl[12] = '{1, 3, 2, 4, 1,0,0,0,  0,0,0,0,1};  // bubble in EX
    tbl[13] = '{0, 0, 0, 0, 0,0,0,0,  2,0,0,1,1};  // load forwarded from WB
    tbl[14] = '{1, 0, 0, 0, 1,1,0,0,  0,0,0,0,1};  // lw x0
    tbl[15] = '{1, 0, 0,11, 1,0,0,0,  0,0,0,1,1};  // reads x0 behind lw x0: no stall
    tbl[16] = '{1, 1, 0,12, 1,1,0,0,  0,0,0,1,1};  // lw x12
    tbl[17] = '{1,12,12,13, 1,0,0,1,  0,0,0,1,1};  // flush kills the stall
    tbl[18] = '{1,12,12,14, 1,0,0,0,  0,0,0,0,1};  // EX is a bubble after flush
    tbl[19] = '{1,14, 0,15, 1,0,1,0,  2,2,0,1,1};  // freeze 1
    tbl[20] = '{1,14, 0,15, 1,0,1,0,  2,2,0,1,1};  // freeze 2
    tbl[21] = '{1,14, 0,15, 1,0,1,0,  2,2,0,1,1};  // freeze 3
    tbl[22] = '{1,14, 0,15, 1,0,0,0,  2,2,0,1,1};  // state held across freeze
    tbl[23] = '{0, 0, 0, 0, 0,0,0,0,  1,0,0,1,1};
    tbl[24] = '{1, 1, 0, 3, 1,1,0,0,  0,0,0,0,1};  // lw x3
    tbl[25] = '{1, 3, 0, 4, 1,0,1,0,  0,0,1,1,1};  // stall while frozen: no count
    tbl[26] = '{1, 3, 0, 4, 1,0,0,0,  0,0,1,1,1};  // stall advances: counts
    tbl[27] = '{1, 3, 0, 4, 1,0,0,0,  0,0,0,0,2};
    tbl[28] = '{0, 0, 0, 0, 0,0,0,0,  2,0,0,1,2};
  end

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst2 = 1'b1;
    idv2 = 1'b1; rs2 = {5'd0, 5'd3}; rd2 = 5'd3; rw2 = 1'b1; ld2 = 1'b1;
    frz2 = 1'b0; fl2 = 1'b0;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #2 check_outs("reset", 0, 0, 0, 0, 0);

    for (int i = 0; i < 29; i++) begin
      drive(tbl[i].v, tbl[i].r0, tbl[i].r1, tbl[i].d, tbl[i].w, tbl[i].l, tbl[i].fz, tbl[i].f);
      #2;
      check_outs($sformatf("row%0d", i), tbl[i].f0, tbl[i].f1, tbl[i].st, tbl[i].ev, tbl[i].c);
      @(posedge clk);
      #1;
    end

    // reset in the middle of a load-use stall, with freeze and flush also high
    drive(1, 0, 0, 5, 1, 1, 0, 0);
    @(posedge clk);
    #1 drive(1, 5, 0, 6, 1, 0, 0, 0);
    #2;
    check("mid.stall", int'(hst), 1);
    check("mid.count", int'(cnt), 2);
    rst = 1'b1; frz = 1'b1; fl = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #2 check_outs("midreset", 0, 0, 0, 0, 0);

    // randomized traffic against the reference model (model is empty after reset)
    for (int n = 0; n < 3000; n++) begin
      int v, r0, r1, d, w, l, fz, f, r;
      bit est;
      v  = ($urandom_range(9, 0) < 7) ? 1 : 0;
      r0 = $urandom_range(3, 0);
      r1 = $urandom_range(3, 0);
      d  = $urandom_range(3, 0);
      w  = ($urandom_range(9, 0) < 8) ? 1 : 0;
      l  = ($urandom_range(9, 0) < 4) ? 1 : 0;
      fz = ($urandom_range(99, 0) < 15) ? 1 : 0;
      f  = ($urandom_range(99, 0) < 10) ? 1 : 0;
      r  = ($urandom_range(99, 0) == 0) ? 1 : 0;
      drive(v, r0, r1, d, w, l, fz, f);
      rst = (r != 0);
      #2;
      est = m_stall(v, r0, r1, f);
      check("rnd.fwd0", int'(fsel[1:0]), m_fwd(m_get(0).rs0));
      check("rnd.fwd1", int'(fsel[3:2]), m_fwd(m_get(0).rs1));
      check("rnd.stall", int'(hst), int'(est));
      check("rnd.ex_valid", int'(exv), int'(m_get(0).valid));
      check("rnd.count", int'(cnt), m_cnt);
      @(posedge clk);
      #1;
      m_update(r, v, r0, r1, d, w, l, fz, f, est);
      rst = 1'b0;
    end

    // saturation: chain of "lw x3,(x3)"; cycle t stalls unless t is a multiple of 32
    rst2 = 1'b0;
    for (int t = 0; t <= 68000; t++) begin
      #2;
      if (t == 1) begin
        check("deep.stall1", int'(hst2), 1);
        check("deep.count1", int'(cnt2), 0);
      end
      if (t == 32000) begin
        check("deep.count32000", int'(cnt2), 32000 - 1000);
        check("deep.nostall", int'(hst2), 0);
        check("deep.bubble_fwd", int'(fsel2[5:0]), 0);
      end
      if (t == 32001) begin
        check("deep.stall", int'(hst2), 1);
        check("deep.fwd_slot32", int'(fsel2[5:0]), 32);
      end
      if (t == 68000) begin
        check("deep.saturated", int'(cnt2), 65535);
      end
      if (t < 68000) begin
        @(posedge clk);
        #1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_forward_unit.md
HAZARD_FORWARD_UNIT -- requirements
Module: hazard_forward_unit

Interface
REQ-001 Parameter REG_ADDR_W, default 5: register-address width.
REQ-002 Parameter NUM_SRC, default 2: source operands per instruction.
REQ-003 Parameter FWD_DEPTH, default 2: forwardable producer slots after EX (1=MEM, 2=WB, ...); min 1.
REQ-004 Parameter LOAD_SLOT, default 2: first slot whose load result is forwardable; range 1..FWD_DEPTH.
REQ-005 Parameter SEL_W, derived: $clog2(FWD_DEPTH+1).
REQ-006 One clock; reset is synchronous and active-high.
REQ-007 clk  in  1  rising-edge clock.
REQ-008 reset  in  1  synchronous active-high reset.
REQ-009 id_valid  in  1  valid instruction in ID.
REQ-010 id_rs  in  NUM_SRC*REG_ADDR_W  ID source registers, source i at bits [i*REG_ADDR_W +: REG_ADDR_W].
REQ-011 id_rd  in  REG_ADDR_W  ID destination register.
REQ-012 id_regwrite  in  1  ID instruction writes rd.
REQ-013 id_is_load  in  1  ID instruction is a load.
REQ-014 freeze  in  1  external pipeline hold, e.g. memory wait.
REQ-015 flush  in  1  kill ID and EX, e.g. taken branch.
REQ-016 fwd_sel  out  NUM_SRC*SEL_W  per-source EX operand select: 0 = register file; k = slot k.
REQ-017 hazard_stall  out  1  hold PC/IF/ID and insert bubble into EX.
REQ-018 ex_valid  out  1  EX slot holds a live instruction.
REQ-019 stall_count  out  16  saturating count of load-use stall cycles.

Function
REQ-020 Tracking pipeline of FWD_DEPTH+1 registered slots, slot 0 = EX; each holds valid, rd, regwrite, is_load; plus registered EX sources ex_rs.
REQ-021 Advance (freeze=0): slot k takes slot k-1 for k>=1; slot 0/ex_rs take ID fields when id_valid=1, hazard_stall=0, flush=0, else a bubble (valid=0).
REQ-022 freeze=1, flush=0: all slots, ex_rs and stall_count hold.
REQ-023 flush=1: slot 0 becomes a bubble next cycle regardless of freeze; slots >=1 shift (freeze=0) or hold (freeze=1).
REQ-024 Producer in slot k (k>=1) matches EX source i when valid=1, regwrite=1, rd!=0, rd==ex_rs[i].
REQ-025 fwd_sel[i] = lowest (youngest) matching k; 0 if no match; combinational from registered state.
REQ-026 Register x0 never forwards, never stalls.
REQ-027 hazard_stall=1 when id_valid=1 and an ID source (nonzero) equals rd of a valid regwrite load in slot j with j+1 < LOAD_SLOT; default: load in slot 0 only.
REQ-028 hazard_stall is combinational; it asserts for exactly as many cycles as the load needs to reach slot LOAD_SLOT-1 (1 cycle for default), provided freeze=0.
REQ-029 flush=1 forces hazard_stall=0.
REQ-030 stall_count increments by 1 each advancing cycle with hazard_stall=1; saturates at 16'hFFFF.
REQ-031 ex_valid = slot 0 valid.

Reset
REQ-032 reset=1 at a clock edge: all slots invalid, ex_rs=0, stall_count=0; hence fwd_sel=0, hazard_stall=0 (while no ID match exists), ex_valid=0.
REQ-033 reset dominates freeze and flush; reset mid-stall drops all tracked producers.

Structure
REQ-034 Shared package holds slot struct type (valid, rd, regwrite, is_load) and the fwd_sel encoding constants (SEL_RF=0).
REQ-035 One sub-module fwd_match_prio: one source vs. all slots -> priority select; instantiated NUM_SRC times.

Verification
REQ-036 Back-to-back ALU: x5 written, next instr reads x5 as src0 -> fwd_sel[0]=1 in its EX cycle; one gap instr -> fwd_sel[0]=2.
REQ-037 Double producer: slot 1 and slot 2 both write x7, EX reads x7 on both sources -> fwd_sel=1 for both sources (youngest wins).
REQ-038 Load-use: lw x3, then add reads x3 -> hazard_stall=1 exactly one cycle, bubble in EX, then fwd_sel=2, stall_count=1.
REQ-039 x0: producer writes x0, consumer reads x0 -> fwd_sel=0, hazard_stall=0.
REQ-040 flush during load-use stall -> hazard_stall=0, slot 0 bubble next cycle, stall_count unchanged; freeze for 3 cycles -> fwd_sel and slots held.
REQ-041 Reset asserted mid-stream -> next cycle all outputs 0; 65,536 stall cycles -> stall_count=16'hFFFF.
